// File: rtl/mrr_pathway_stream_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mrr_pathway_stream_arbiter_pkg
//
// Shared definitions for the pathway stream arbiter and its helpers:
//   - per-packet header word layout (marker, pathway index, sequence number)
//   - stream FSM state encoding
//   - index-width helper used to size pathway index ports
//
// No ports (package).
// -----------------------------------------------------------------------------
package mrr_pathway_stream_arbiter_pkg;

    // Header word layout (low 32 bits of the stream word):
    //   [31:24] marker, [23:16] pathway index, [15:0] sequence number
    localparam logic [7:0] HDR_MARKER     = 8'hA5;
    localparam int         HDR_MARKER_LSB = 24;
    localparam int         HDR_IDX_LSB    = 16;
    localparam int         HDR_SEQ_LSB    = 0;
    localparam int         SEQ_WIDTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_DROP   = 2'd3
    } arb_state_e;

    // Width of an index able to address n entries (never narrower than 1 bit).
    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] build_header(input logic [7:0]           idx,
                                                 input logic [SEQ_WIDTH-1:0] seq);
        logic [31:0] w;
        w = '0;
        w[HDR_MARKER_LSB +: 8]       = HDR_MARKER;
        w[HDR_IDX_LSB    +: 8]       = idx;
        w[HDR_SEQ_LSB    +: SEQ_WIDTH] = seq;
        return w;
    endfunction

endpackage

// File: rtl/mrr_pathway_stream_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mrr_rr_arbiter
//
// Combinational round-robin picker. Scans req starting one position after
// last_grant (wrapping at NUM_REQ) and returns the first asserted request.
// With last_grant = NUM_REQ-1 it degenerates to a lowest-index-first picker.
//
// Ports:
//   req         in   NUM_REQ    request vector
//   last_grant  in   IDX_WIDTH  index granted most recently
//   gnt_onehot  out  NUM_REQ    one-hot winner (all zero when no request)
//   gnt_idx     out  IDX_WIDTH  winner index (0 when no request)
//   gnt_valid   out  1          at least one request present
// -----------------------------------------------------------------------------
module mrr_rr_arbiter
    import mrr_pathway_stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]   gnt_onehot,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 gnt_valid
);

    always_comb begin
        int                   cand;
        logic [IDX_WIDTH-1:0] cidx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        cand       = 0;
        cidx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            cidx = IDX_WIDTH'(cand);
            if (!gnt_valid && req[cidx]) begin
                gnt_valid        = 1'b1;
                gnt_onehot[cidx] = 1'b1;
                gnt_idx          = cidx;
            end
        end
    end

endmodule

// File: rtl/mrr_pathway_stream_arbiter.sv
// -----------------------------------------------------------------------------
// mrr_pathway_stream_arbiter
//
// Merges NUM_PATHWAYS AXI-stream inputs into one host stream. Arbitration is
// round-robin per packet with an optional header word in front of every
// packet. Packets longer than 2^MAX_PKT_LOG2 beats are cut: the last kept
// beat carries a forced tlast and the remainder is discarded. A separate
// block resolves ownership of the shared transmitter among tx_en_in requests.
//
// Ports:
//   clk              in   1                        clock
//   rst              in   1                        async reset, active low
//   header_en        in   1                        prepend header (sampled in IDLE)
//   clear_counters   in   1                        sync clear of diag counters
//   i_tdata          in   NUM_PATHWAYS*DATA_WIDTH  pathway p at [DW*(p+1)-1 -: DW]
//   i_tlast          in   NUM_PATHWAYS             per-pathway end of packet
//   i_tvalid         in   NUM_PATHWAYS             per-pathway valid
//   i_tready         out  NUM_PATHWAYS             per-pathway ready
//   o_tdata          out  DATA_WIDTH               merged data (registered)
//   o_tuser          out  IDX_WIDTH                source pathway of beat
//   o_tlast          out  1                        merged end of packet
//   o_tvalid         out  1                        merged valid
//   o_tready         in   1                        downstream ready
//   tx_en_in         in   NUM_PATHWAYS             per-pathway transmit request
//   tx_en_out        out  1                        registered transmit enable
//   tx_owner         out  IDX_WIDTH                current transmitter owner
//   tx_collision     out  1                        one-cycle contention pulse
//   collision_count  out  CNT_WIDTH                saturating collision count
//   trunc_count      out  CNT_WIDTH                saturating truncation count
// -----------------------------------------------------------------------------
module mrr_pathway_stream_arbiter
    import mrr_pathway_stream_arbiter_pkg::*;
#(
    parameter int NUM_PATHWAYS = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int IDX_WIDTH    = idx_bits(NUM_PATHWAYS),
    parameter int MAX_PKT_LOG2 = 10,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               header_en,
    input  logic                               clear_counters,
    input  logic [NUM_PATHWAYS*DATA_WIDTH-1:0] i_tdata,
    input  logic [NUM_PATHWAYS-1:0]            i_tlast,
    input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
    output logic [NUM_PATHWAYS-1:0]            i_tready,
    output logic [DATA_WIDTH-1:0]              o_tdata,
    output logic [IDX_WIDTH-1:0]               o_tuser,
    output logic                               o_tlast,
    output logic                               o_tvalid,
    input  logic                               o_tready,
    input  logic [NUM_PATHWAYS-1:0]            tx_en_in,
    output logic                               tx_en_out,
    output logic [IDX_WIDTH-1:0]               tx_owner,
    output logic                               tx_collision,
    output logic [CNT_WIDTH-1:0]               collision_count,
    output logic [CNT_WIDTH-1:0]               trunc_count
);

    localparam logic [MAX_PKT_LOG2-1:0] BEAT_LAST = '1;
    localparam logic [IDX_WIDTH-1:0]    IDX_TOP   = IDX_WIDTH'(NUM_PATHWAYS - 1);

    // ------------------------------------------------------------------
    // Stream arbitration state
    // ------------------------------------------------------------------
    arb_state_e                  state, state_nxt;
    logic [IDX_WIDTH-1:0]        sel;
    logic [NUM_PATHWAYS-1:0]     sel_onehot;
    logic [IDX_WIDTH-1:0]        last_grant;
    logic [SEQ_WIDTH-1:0]        seq [NUM_PATHWAYS];
    logic [MAX_PKT_LOG2-1:0]     beat_cnt;

    logic [DATA_WIDTH-1:0]       lane [NUM_PATHWAYS];
    logic [NUM_PATHWAYS-1:0]     gnt_onehot;
    logic [IDX_WIDTH-1:0]        gnt_idx;
    logic                        gnt_valid;

    logic                        out_load;
    logic                        cur_valid;
    logic                        cur_last;
    logic [DATA_WIDTH-1:0]       cur_data;
    logic [DATA_WIDTH-1:0]       hdr_word;

    logic                        grant_take;
    logic                        word_ld;
    logic [DATA_WIDTH-1:0]       word_data;
    logic                        word_last;
    logic                        beat_acc;
    logic                        pkt_done;
    logic                        trunc_hit;

    for (genvar p = 0; p < NUM_PATHWAYS; p++) begin : g_lane
        assign lane[p] = i_tdata[DATA_WIDTH*(p+1)-1 -: DATA_WIDTH];
    end

    mrr_rr_arbiter #(
        .NUM_REQ   (NUM_PATHWAYS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_stream_rr (
        .req        (i_tvalid),
        .last_grant (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // The output register may take a new word when empty or being drained.
    assign out_load  = !o_tvalid || o_tready;
    assign cur_valid = i_tvalid[sel];
    assign cur_last  = i_tlast[sel];
    assign cur_data  = lane[sel];
    assign hdr_word  = DATA_WIDTH'(build_header(8'(sel), seq[sel]));

    always_comb begin
        state_nxt  = state;
        i_tready   = '0;
        grant_take = 1'b0;
        word_ld    = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        beat_acc   = 1'b0;
        pkt_done   = 1'b0;
        trunc_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_take = 1'b1;
                    state_nxt  = header_en ? ST_HEADER : ST_DATA;
                end
            end
            ST_HEADER: begin
                if (out_load) begin
                    word_ld   = 1'b1;
                    word_data = hdr_word;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                i_tready = sel_onehot & {NUM_PATHWAYS{out_load}};
                if (cur_valid && out_load) begin
                    beat_acc  = 1'b1;
                    word_ld   = 1'b1;
                    word_data = cur_data;
                    if (cur_last) begin
                        word_last = 1'b1;
                        pkt_done  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (beat_cnt == BEAT_LAST) begin
                        // Runaway packet: close it on this beat, swallow the rest.
                        word_last = 1'b1;
                        pkt_done  = 1'b1;
                        trunc_hit = 1'b1;
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                i_tready = sel_onehot;
                if (cur_valid && cur_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_onehot <= '0;
            last_grant <= IDX_TOP;
            beat_cnt   <= '0;
            for (int p = 0; p < NUM_PATHWAYS; p++) begin
                seq[p] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (grant_take) begin
                sel        <= gnt_idx;
                sel_onehot <= gnt_onehot;
                last_grant <= gnt_idx;
            end
            if (pkt_done) begin
                seq[sel] <= seq[sel] + 1'b1;
            end
            if (pkt_done) begin
                beat_cnt <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tuser  <= '0;
            o_tlast  <= 1'b0;
        end else if (out_load) begin
            o_tvalid <= word_ld;
            if (word_ld) begin
                o_tdata <= word_data;
                o_tuser <= sel;
                o_tlast <= word_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trunc_count <= '0;
        end else if (clear_counters) begin
            trunc_count <= '0;
        end else if (trunc_hit && (trunc_count != '1)) begin
            trunc_count <= trunc_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter ownership
    // ------------------------------------------------------------------
    logic                    tx_active;
    logic [NUM_PATHWAYS-1:0] tx_en_prev;
    logic [NUM_PATHWAYS-1:0] tx_rise;
    logic [NUM_PATHWAYS-1:0] owner_oh;
    logic [NUM_PATHWAYS-1:0] tx_pick_oh;
    logic [IDX_WIDTH-1:0]    tx_pick_idx;
    logic                    tx_pick_valid;
    logic                    tx_coll;

    // Starting the scan after the top index makes this a lowest-index-first pick.
    mrr_rr_arbiter #(
        .NUM_REQ   (NUM_PATHWAYS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_tx_pick (
        .req        (tx_en_in),
        .last_grant (IDX_TOP),
        .gnt_onehot (tx_pick_oh),
        .gnt_idx    (tx_pick_idx),
        .gnt_valid  (tx_pick_valid)
    );

    always_comb begin
        tx_rise            = tx_en_in & ~tx_en_prev;
        owner_oh           = '0;
        owner_oh[tx_owner] = 1'b1;
        if (tx_active) begin
            tx_coll = |(tx_rise & ~owner_oh);
        end else begin
            // Simultaneous rises with no owner: loser rises count as contention.
            tx_coll = tx_pick_valid && |(tx_rise & ~tx_pick_oh);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_active    <= 1'b0;
            tx_owner     <= '0;
            tx_en_out    <= 1'b0;
            tx_en_prev   <= '0;
            tx_collision <= 1'b0;
        end else begin
            tx_en_prev   <= tx_en_in;
            tx_collision <= tx_coll;
            if (tx_active) begin
                tx_en_out <= tx_en_in[tx_owner];
                if (!tx_en_in[tx_owner]) begin
                    tx_active <= 1'b0;
                end
            end else if (tx_pick_valid) begin
                tx_active <= 1'b1;
                tx_owner  <= tx_pick_idx;
                tx_en_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision_count <= '0;
        end else if (clear_counters) begin
            collision_count <= '0;
        end else if (tx_coll && (collision_count != '1)) begin
            collision_count <= collision_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mrr_pathway_stream_arbiter.sv
module tb_mrr_pathway_stream_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int IW    = 2;
    localparam int MPL   = 6;
    localparam int CW    = 16;
    localparam int MAXB  = 1 << MPL;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              header_en;
    logic              clear_counters;
    logic [N*DW-1:0]   i_tdata;
    logic [N-1:0]      i_tlast;
    logic [N-1:0]      i_tvalid;
    logic [N-1:0]      i_tready;
    logic [DW-1:0]     o_tdata;
    logic [IW-1:0]     o_tuser;
    logic              o_tlast;
    logic              o_tvalid;
    logic              o_tready;
    logic [N-1:0]      tx_en_in;
    logic              tx_en_out;
    logic [IW-1:0]     tx_owner;
    logic              tx_collision;
    logic [CW-1:0]     collision_count;
    logic [CW-1:0]     trunc_count;

    mrr_pathway_stream_arbiter #(
        .NUM_PATHWAYS (N),
        .DATA_WIDTH   (DW),
        .IDX_WIDTH    (IW),
        .MAX_PKT_LOG2 (MPL),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .header_en       (header_en),
        .clear_counters  (clear_counters),
        .i_tdata         (i_tdata),
        .i_tlast         (i_tlast),
        .i_tvalid        (i_tvalid),
        .i_tready        (i_tready),
        .o_tdata         (o_tdata),
        .o_tuser         (o_tuser),
        .o_tlast         (o_tlast),
        .o_tvalid        (o_tvalid),
        .o_tready        (o_tready),
        .tx_en_in        (tx_en_in),
        .tx_en_out       (tx_en_out),
        .tx_owner        (tx_owner),
        .tx_collision    (tx_collision),
        .collision_count (collision_count),
        .trunc_count     (trunc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] u;
        logic          l;
    } obeat_t;

    // Per-pathway source packets (data + last flag) and read/write pointers.
    logic [DW-1:0] src_d [N][DEPTH];
    logic          src_l [N][DEPTH];
    int            src_wr [N];
    int            src_rd [N];
    bit            src_first [N];

    obeat_t        exp_q[$];
    int            m_lg;
    int            m_seq [N];
    int            m_trunc;
    bit            rdy_rand;
    bit            gaps;

    int checks = 0;
    int errors = 0;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_bench_model();
        for (int p = 0; p < N; p++) begin
            src_wr[p]    = 0;
            src_rd[p]    = 0;
            src_first[p] = 1'b1;
            m_seq[p]     = 0;
        end
        exp_q.delete();
        m_lg    = N - 1;
        m_trunc = 0;
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            src_d[p][src_wr[p]] = $urandom;
            src_l[p][src_wr[p]] = (i == len - 1);
            src_wr[p]++;
        end
    endtask

    function automatic bit pending();
        bit any;
        any = 1'b0;
        for (int p = 0; p < N; p++) if (src_rd[p] < src_wr[p]) any = 1'b1;
        return any;
    endfunction

    // Expected host stream: with every queued packet already presented, the
    // grant order is plain round robin over pathways that still hold packets.
    task automatic build_model(input bit hdr);
        int     mp [N];
        int     g;
        int     c;
        int     cnt;
        bit     cut;
        logic   l;
        logic [DW-1:0] d;
        obeat_t b;
        for (int p = 0; p < N; p++) mp[p] = src_rd[p];
        forever begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_lg + k) % N;
                if (g < 0 && mp[c] < src_wr[c]) g = c;
            end
            if (g < 0) break;
            m_lg = g;
            if (hdr) begin
                b.d = DW'({8'hA5, 8'(g), 16'(m_seq[g])});
                b.u = IW'(g);
                b.l = 1'b0;
                exp_q.push_back(b);
            end
            cnt = 0;
            cut = 1'b0;
            do begin
                d = src_d[g][mp[g]];
                l = src_l[g][mp[g]];
                mp[g]++;
                if (!cut) begin
                    b.d = d;
                    b.u = IW'(g);
                    if (cnt == MAXB - 1 && !l) begin
                        b.l = 1'b1;
                        cut = 1'b1;
                        m_trunc++;
                    end else begin
                        b.l = l;
                    end
                    exp_q.push_back(b);
                    cnt++;
                end
            end while (!l);
            m_seq[g] = (m_seq[g] + 1) % 65536;
        end
    endtask

    task automatic drive(input logic [N-1:0] ihs);
        for (int p = 0; p < N; p++) begin
            if (src_rd[p] < src_wr[p]) begin
                i_tdata[p*DW +: DW] = src_d[p][src_rd[p]];
                i_tlast[p]          = src_l[p][src_rd[p]];
                if (i_tvalid[p] && !ihs[p]) i_tvalid[p] = 1'b1;
                else i_tvalid[p] = src_first[p] || !gaps || ($urandom_range(3) != 0);
            end else begin
                i_tdata[p*DW +: DW] = '0;
                i_tlast[p]          = 1'b0;
                i_tvalid[p]         = 1'b0;
            end
        end
        o_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic step();
        logic [N-1:0] ihs;
        logic         ohs;
        logic         stalled;
        obeat_t       got;
        obeat_t       e;
        @(negedge clk);
        ihs     = i_tvalid & i_tready;
        ohs     = o_tvalid & o_tready;
        stalled = o_tvalid & ~o_tready;
        got.d   = o_tdata;
        got.u   = o_tuser;
        got.l   = o_tlast;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (ihs[p]) begin
                src_first[p] = src_l[p][src_rd[p]];
                src_rd[p]++;
            end
        end
        if (ohs) begin
            chk("out_beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_beat", {got.d, got.u, got.l}, {e.d, e.u, e.l});
            end
        end
        if (stalled) begin
            chk("stall_hold", {o_tvalid, o_tdata, o_tuser, o_tlast},
                {1'b1, got.d, got.u, got.l});
        end
        drive(ihs);
    endtask

    task automatic start(input bit hdr, input bit rr, input bit gp);
        header_en = hdr;
        rdy_rand  = rr;
        gaps      = gp;
        build_model(hdr);
        drive('0);
    endtask

    task automatic run_drain(input string tag, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || pending()) && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_drained"}, 64'(c < budget), 64'd1);
        repeat (3) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_o_tvalid"}, o_tvalid, 0);
        chk({tag, "_o_tdata"}, o_tdata, 0);
        chk({tag, "_o_tuser"}, o_tuser, 0);
        chk({tag, "_o_tlast"}, o_tlast, 0);
        chk({tag, "_i_tready"}, i_tready, 0);
        chk({tag, "_tx_en_out"}, tx_en_out, 0);
        chk({tag, "_tx_owner"}, tx_owner, 0);
        chk({tag, "_tx_collision"}, tx_collision, 0);
        chk({tag, "_collision_count"}, collision_count, 0);
        chk({tag, "_trunc_count"}, trunc_count, 0);
    endtask

    initial begin
        rst            = 1'b0;
        header_en      = 1'b0;
        clear_counters = 1'b0;
        i_tdata        = '0;
        i_tlast        = '0;
        i_tvalid       = '0;
        o_tready       = 1'b1;
        tx_en_in       = '0;
        rdy_rand       = 1'b0;
        gaps           = 1'b0;
        reset_bench_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 rst = 1'b1;
        cyc();
        chk("idle_i_tready", i_tready, 0);
        chk("idle_o_tvalid", o_tvalid, 0);

        // Transmitter ownership
        tx_en_in = 4'b0100;
        cyc();
        chk("tx_owner_first", tx_owner, 2);
        chk("tx_en_out_first", tx_en_out, 1);
        chk("tx_coll_none", tx_collision, 0);
        tx_en_in = 4'b0101;
        cyc();
        chk("tx_coll_pulse", tx_collision, 1);
        chk("tx_coll_count1", collision_count, 1);
        chk("tx_owner_kept", tx_owner, 2);
        cyc();
        chk("tx_coll_pulse_end", tx_collision, 0);
        chk("tx_coll_count_hold", collision_count, 1);
        tx_en_in = 4'b0001;
        cyc();
        chk("tx_release_en", tx_en_out, 0);
        chk("tx_release_owner_hold", tx_owner, 2);
        cyc();
        chk("tx_rearb_owner", tx_owner, 0);
        chk("tx_rearb_en", tx_en_out, 1);
        chk("tx_rearb_no_coll", tx_collision, 0);
        tx_en_in       = 4'b0011;
        clear_counters = 1'b1;
        cyc();
        clear_counters = 1'b0;
        chk("tx_clear_pulse", tx_collision, 1);
        chk("tx_clear_wins", collision_count, 0);
        cyc();
        chk("tx_after_clear", collision_count, 0);
        tx_en_in = 4'b0000;
        cyc();
        chk("tx_drop_en", tx_en_out, 0);
        cyc();
        chk("tx_idle_owner_hold", tx_owner, 0);
        chk("tx_idle_en", tx_en_out, 0);
        tx_en_in = 4'b0110;
        cyc();
        chk("tx_simul_owner", tx_owner, 1);
        chk("tx_simul_en", tx_en_out, 1);
        chk("tx_simul_pulse", tx_collision, 1);
        chk("tx_simul_count", collision_count, 1);

        // Pathways 0 and 2 alternate packet by packet
        for (int i = 0; i < 3; i++) begin
            add_pkt(0, 3);
            add_pkt(2, 3);
        end
        start(1'b0, 1'b0, 1'b0);
        run_drain("alt02", 200);

        // Headers carry pathway index and per-pathway sequence number
        add_pkt(1, 3);
        add_pkt(1, 3);
        start(1'b1, 1'b0, 1'b0);
        run_drain("hdr1", 100);

        // Runaway packet cut at the maximum length
        add_pkt(3, MAXB + 2);
        start(1'b0, 1'b0, 1'b0);
        run_drain("trunc", 400);
        chk("trunc_count_one", trunc_count, 64'(m_trunc));

        // Exactly maximum-length packet under random back-pressure
        add_pkt(2, MAXB);
        start(1'b0, 1'b1, 1'b0);
        run_drain("maxlen_stall", 1000);
        chk("trunc_count_maxlen", trunc_count, 64'(m_trunc));

        // Random mixes, with and without headers
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) begin
                for (int k = 0; k < 3; k++) add_pkt(p, $urandom_range(MAXB + 6, 1));
            end
            start(r[0], 1'b1, 1'b1);
            run_drain("random_mix", 8000);
            chk("trunc_count_random", trunc_count, 64'(m_trunc));
        end
        chk("collision_count_kept", collision_count, 1);

        // Asynchronous reset in the middle of a packet
        add_pkt(1, 40);
        start(1'b0, 1'b0, 1'b0);
        repeat (10) step();
        #3 rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        tx_en_in = '0;
        reset_bench_model();
        repeat (2) cyc();
        #2 rst = 1'b1;
        cyc();
        for (int p = N - 1; p >= 0; p--) add_pkt(p, 2);
        start(1'b1, 1'b0, 1'b0);
        run_drain("post_reset", 200);
        chk("post_reset_trunc", trunc_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrr_pathway_stream_arbiter.md
Name: mrr_pathway_stream_arbiter

Overview:
- Merges NUM_PATHWAYS per-pathway AXI-stream decode outputs into one stream toward the host.
- Arbitration is packet-granular round-robin. Optionally prepends a per-packet header word carrying pathway index and sequence number.
- Truncates runaway packets and resolves shared-transmitter ownership among the pathway tx_en requests.
- Sits between the decode pathways' loopback outputs and the single host return stream.

Parameters:
- NUM_PATHWAYS, 4, number of input streams (>=2).
- DATA_WIDTH, 32, stream word width (>=32).
- IDX_WIDTH, 2, pathway index width, ceil(log2(NUM_PATHWAYS)).
- MAX_PKT_LOG2, 10, maximum payload beats per packet is 2^MAX_PKT_LOG2.
- CNT_WIDTH, 16, width of diagnostic counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- header_en  in  1  prepend header word; sampled only in IDLE.
- clear_counters  in  1  synchronous clear of diagnostic counters.
- i_tdata  in  NUM_PATHWAYS*DATA_WIDTH  pathway p occupies bits [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH].
- i_tlast  in  NUM_PATHWAYS  per-pathway end of packet.
- i_tvalid  in  NUM_PATHWAYS  per-pathway valid.
- i_tready  out  NUM_PATHWAYS  per-pathway ready.
- o_tdata  out  DATA_WIDTH  merged data.
- o_tuser  out  IDX_WIDTH  source pathway of current beat.
- o_tlast  out  1  merged end of packet.
- o_tvalid  out  1  merged valid.
- o_tready  in  1  downstream ready.
- tx_en_in  in  NUM_PATHWAYS  per-pathway transmit request.
- tx_en_out  out  1  registered transmit enable.
- tx_owner  out  IDX_WIDTH  pathway currently owning the transmitter.
- tx_collision  out  1  one-cycle pulse on contention.
- collision_count  out  CNT_WIDTH  saturating count of collisions.
- trunc_count  out  CNT_WIDTH  saturating count of truncated packets.

Behaviour:

Reset (rst low, async):
- All outputs 0. FSM to IDLE. last_grant = NUM_PATHWAYS-1. Sequence numbers, beat counter and counters 0.

Output stage:
- o_tdata, o_tuser, o_tlast and o_tvalid are registered.
- A word loads when (!o_tvalid | o_tready). o_* are held stable while o_tvalid & !o_tready.
- Sustained throughput is one beat per cycle.

FSM states: IDLE, HEADER, DATA, DROP.
- IDLE:
  - Scan i_tvalid round-robin starting at last_grant+1 (mod NUM_PATHWAYS); the first asserted wins.
  - Latch sel and header_en; last_grant <= sel.
  - Go to HEADER if header_en, else DATA. No beat is accepted in IDLE, so there is one idle cycle per grant.
  - No valid input: remain in IDLE.
- HEADER:
  - When the output stage can load, emit {DATA_WIDTH-32 zeros, 8'hA5, sel zero-extended to 8 bits, seq[sel][15:0]} with o_tlast=0. Go to DATA.
- DATA:
  - i_tready[sel] = (!o_tvalid | o_tready). All other i_tready are 0.
  - Each accepted beat is forwarded with o_tuser=sel, and beat_cnt increments.
  - tlast accepted: o_tlast=1, seq[sel]++ (wraps at 16 bits), beat_cnt<=0, go to IDLE.
  - beat_cnt == 2^MAX_PKT_LOG2-1 and accepted beat lacks tlast: force o_tlast=1, trunc_count++ (saturating), seq[sel]++, go to DROP.
- DROP:
  - i_tready[sel]=1 and beats are discarded.
  - On accepted tlast, go to IDLE.
- The header word does not count toward beat_cnt.
- Sequence numbers are per pathway and advance once per emitted packet, including truncated packets.

tx ownership (independent of stream FSM):
- No owner and any tx_en_in set: owner = lowest set index; tx_en_out<=1 next cycle.
- Owner active: tx_en_out follows tx_en_in[owner]. When it drops, release on the next cycle, then re-arbitrate.
- Any non-owner tx_en_in rising edge while owner active: tx_collision pulses 1 cycle; collision_count++ (saturating). The owner is not changed.
- Simultaneous rises with no owner: lowest index wins, counted as one collision.
- tx_owner holds its last value when idle.

Counters:
- clear_counters wins over a same-cycle increment.
- Counters saturate at all-ones.

Decomposition:
- Shared package: header marker 8'hA5, header field offsets, FSM state encoding, and the IDX_WIDTH ceil-log2 helper.
- One sub-module: mrr_rr_arbiter (NUM_PATHWAYS requests, last_grant in, one-hot/index grant out, combinational), reusable by other pathway muxes.

Test Plan:
- Pathways 0 and 2 each present 3-beat packets continuously, header_en=0 -> output alternates 0,2,0,2. o_tuser matches. No interleaving within a packet.
- header_en=1, pathway 1 sends two packets -> first words 0xA5010000 then 0xA5010001, each followed by the payload.
- MAX_PKT_LOG2=2, pathway 3 sends 6 beats then tlast -> 4 beats out with o_tlast on beat 4. Beats 5-6 are dropped. trunc_count=1.
- o_tready toggled 50% random during a 64-beat packet -> output exactly equals input, no drops or duplicates, o_* stable while stalled.
- tx_en_in=0b0100, then 0b0101 -> tx_owner=2, one tx_collision pulse, collision_count=1. Drop bit 2 -> release, then owner=0.
- rst low mid-packet in DATA -> all outputs 0 immediately. After release, arbitration restarts at pathway 0.
